// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - game stage controller: stages 1 -> 2 -> 4 -> win, kill score, frame-counted pauses
// Optional lives/replay support is compiled in with STAGE_SEQ_LIVES_EN.
module stage_sequencer #(
    parameter int PAUSE_FRAMES    = 60,
    parameter int SCORE_WIDTH     = 16,
    parameter int POINTS_PER_KILL = 10,
    parameter int LIVES           = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   start_game,
    input  logic                   monster_died_pulse,
    input  logic                   all_monsters_dead,
    input  logic                   player_dead,
    output logic [2:0]             stage_num,
    output logic                   monsters_enable,
    output logic                   stage_resetN,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [1:0]             lives,
    output logic                   game_over,
    output logic                   game_won
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_PAUSE, S_WIN, S_LOSE} state_t;

    localparam int PF_EFF = (PAUSE_FRAMES < 1) ? 1 : PAUSE_FRAMES;
    localparam int CNT_W  = (PF_EFF < 2) ? 1 : $clog2(PF_EFF);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(PF_EFF - 1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;
`ifdef STAGE_SEQ_LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
`else
    // Single life; LIVES only matters when the lives feature is built in.
    localparam logic [1:0] LIVES_INIT = (LIVES != 0) ? 2'd1 : 2'd1;
`endif

    state_t                 r_state, w_next_state;
    logic [2:0]             r_next_stage, w_next_stage;
    logic                   r_settle, w_settle;
    logic [CNT_W-1:0]       r_pause_cnt, w_pause_cnt;
    logic [SCORE_WIDTH-1:0] r_score, w_score;
    logic [SCORE_WIDTH:0]   w_score_sum;
    logic [1:0]             r_lives, w_lives;
    logic                   r_was_play;
    logic                   w_kill, w_player_hit;
    logic [2:0]             r_stage_num, w_stage_num;
    logic                   r_enable, w_enable;
    logic                   r_stage_resetN, w_stage_resetN;
    logic                   r_over, w_over;
    logic                   r_won, w_won;

`ifdef STAGE_SEQ_LIVES_EN
    logic r_player_dead_d;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_player_dead_d <= 1'b0;
        else         r_player_dead_d <= player_dead;
    end
    assign w_player_hit = player_dead & ~r_player_dead_d;
`else
    assign w_player_hit = player_dead;
`endif

    // Kills still count in the first PAUSE cycle so a last-monster hit is not lost.
    assign w_kill      = monster_died_pulse &&
                         (r_state == S_PLAY || (r_state == S_PAUSE && r_was_play));
    assign w_score_sum = {1'b0, r_score} + (SCORE_WIDTH + 1)'(POINTS_PER_KILL);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_stage = r_next_stage;
        w_settle     = r_settle;
        w_pause_cnt  = r_pause_cnt;
        w_lives      = r_lives;
        w_score      = r_score;
        if (w_kill) w_score = w_score_sum[SCORE_WIDTH] ? SCORE_MAX : w_score_sum[SCORE_WIDTH-1:0];
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_game) begin
                    w_next_state = S_LOAD;
                    w_next_stage = 3'd1;
                    w_score      = '0;
                    w_lives      = LIVES_INIT;
                end
            end
            S_LOAD: begin
                w_next_state = S_PLAY;
                w_settle     = 1'b0;
            end
            S_PLAY: begin
                if (startOfFrame) w_settle = 1'b1;
                if (w_player_hit) begin
`ifdef STAGE_SEQ_LIVES_EN
                    if (r_lives > 2'd1) begin
                        w_lives      = r_lives - 2'd1;
                        w_next_state = S_LOAD;
                    end else begin
                        w_lives      = 2'd0;
                        w_next_state = S_LOSE;
                    end
`else
                    w_next_state = S_LOSE;
`endif
                end else if (all_monsters_dead && r_settle) begin
                    if (r_next_stage == 3'd4) begin
                        w_next_state = S_WIN;
                    end else begin
                        w_next_stage = (r_next_stage == 3'd1) ? 3'd2 : 3'd4;
                        w_pause_cnt  = '0;
                        w_next_state = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (startOfFrame) begin
                    if (r_pause_cnt == CNT_LAST) begin
                        w_pause_cnt  = '0;
                        w_next_state = S_LOAD;
                    end else begin
                        w_pause_cnt = r_pause_cnt + 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land together with it.
    always_comb begin
        w_enable       = (w_next_state == S_PLAY);
        w_stage_resetN = (w_next_state != S_LOAD);
        w_over         = (w_next_state == S_LOSE);
        w_won          = (w_next_state == S_WIN);
        case (w_next_state)
            S_LOAD:          w_stage_num = w_next_stage;
            S_PLAY, S_PAUSE: w_stage_num = r_stage_num;
            default:         w_stage_num = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_next_stage   <= 3'd1;
            r_settle       <= 1'b0;
            r_pause_cnt    <= '0;
            r_score        <= '0;
            r_lives        <= LIVES_INIT;
            r_was_play     <= 1'b0;
            r_stage_num    <= 3'd0;
            r_enable       <= 1'b0;
            r_stage_resetN <= 1'b1;
            r_over         <= 1'b0;
            r_won          <= 1'b0;
        end else begin
            r_next_stage   <= w_next_stage;
            r_settle       <= w_settle;
            r_pause_cnt    <= w_pause_cnt;
            r_score        <= w_score;
            r_lives        <= w_lives;
            r_was_play     <= (r_state == S_PLAY);
            r_stage_num    <= w_stage_num;
            r_enable       <= w_enable;
            r_stage_resetN <= w_stage_resetN;
            r_over         <= w_over;
            r_won          <= w_won;
        end
    end

    assign stage_num       = r_stage_num;
    assign monsters_enable = r_enable;
    assign stage_resetN    = r_stage_resetN;
    assign score           = r_score;
    assign lives           = r_lives;
    assign game_over       = r_over;
    assign game_won        = r_won;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized scenario bench for stage_sequencer against an arithmetic score/stage model
module tb_stage_sequencer;
    logic        clk = 1'b0;
    logic        resetN, sof, start, died, alld, pdead;
    logic [2:0]  stage_num, stage_num8;
    logic        en, en8, srst, srst8, over, over8, won, won8;
    logic [15:0] score;
    logic [7:0]  score8;
    logic [1:0]  lives, lives8;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_score  = 0;
    int exp_score8 = 0;
`ifdef STAGE_SEQ_LIVES_EN
    int exp_lives = 3;
`else
    int exp_lives = 1;
`endif

    stage_sequencer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start),
        .monster_died_pulse(died), .all_monsters_dead(alld), .player_dead(pdead),
        .stage_num(stage_num), .monsters_enable(en), .stage_resetN(srst),
        .score(score), .lives(lives), .game_over(over), .game_won(won)
    );

    stage_sequencer #(.SCORE_WIDTH(8)) dut8 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start),
        .monster_died_pulse(died), .all_monsters_dead(alld), .player_dead(pdead),
        .stage_num(stage_num8), .monsters_enable(en8), .stage_resetN(srst8),
        .score(score8), .lives(lives8), .game_over(over8), .game_won(won8)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // One monster_died_pulse cycle in a scoring state: both score models advance.
    task automatic kill_cycle();
        died = 1'b1;
        cyc();
        died = 1'b0;
        exp_score  = sat(exp_score + 10, 65535);
        exp_score8 = sat(exp_score8 + 10, 255);
    endtask

    task automatic test_reset();
        resetN = 1'b0; sof = 0; start = 0; died = 0; alld = 0; pdead = 0;
        cyc(); cyc();
        n_tests++;
        if (stage_num !== 3'd0 || en !== 1'b0 || srst !== 1'b1 || over !== 1'b0 || won !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stage=%0d en=%0b srst=%0b over=%0b won=%0b required 0 0 1 0 0",
                     stage_num, en, srst, over, won);
        end
        n_tests++;
        if (score !== 16'd0 || lives !== 2'(exp_lives)) begin
            n_fail++;
            $display("FAIL reset_score_lives: got score=%0d lives=%0d required 0 %0d", score, lives, exp_lives);
        end
        resetN = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_score = 0; exp_score8 = 0;
        n_tests++;
        if (srst !== 1'b0 || stage_num !== 3'd1 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL start_load: got srst=%0b stage=%0d en=%0b required 0 1 0", srst, stage_num, en);
        end
        cyc();
        n_tests++;
        if (srst !== 1'b1 || stage_num !== 3'd1 || en !== 1'b1 || score !== 16'd0) begin
            n_fail++;
            $display("FAIL start_play: got srst=%0b stage=%0d en=%0b score=%0d required 1 1 1 0",
                     srst, stage_num, en, score);
        end
    endtask

    // Clears a stage from PLAY; with held=1 all_monsters_dead has been high since LOAD.
    task automatic play_clear(input int stage, input bit held);
        int waited;
        if (held) begin
            repeat ($urandom_range(2, 6)) begin
                cyc();
                n_tests++;
                if (en !== 1'b1 || stage_num !== 3'(stage)) begin
                    n_fail++;
                    $display("FAIL settle_hold: got en=%0b stage=%0d required 1 %0d", en, stage_num, stage);
                end
            end
            sof = 1'b1; cyc(); sof = 1'b0;
            waited = 0;
            while (en === 1'b1 && waited < 3) begin
                cyc();
                waited++;
            end
            alld = 1'b0;
            n_tests++;
            if (en !== 1'b0 || stage_num !== 3'(stage)) begin
                n_fail++;
                $display("FAIL settle_advance: got en=%0b stage=%0d required 0 %0d", en, stage_num, stage);
            end
        end else begin
            sof = 1'b1; cyc(); sof = 1'b0;
            repeat ($urandom_range(1, 6)) begin
                kill_cycle();
                repeat ($urandom_range(0, 2)) cyc();
            end
            alld = 1'b1;
            died = 1'($urandom_range(0, 1));
            cyc();
            if (died) begin
                exp_score  = sat(exp_score + 10, 65535);
                exp_score8 = sat(exp_score8 + 10, 255);
            end
            alld = 1'b0; died = 1'b0;
            n_tests++;
            if (stage == 4) begin
                if (won !== 1'b1 || en !== 1'b0 || stage_num !== 3'd0 || over !== 1'b0) begin
                    n_fail++;
                    $display("FAIL win_state: got won=%0b en=%0b stage=%0d over=%0b required 1 0 0 0",
                             won, en, stage_num, over);
                end
            end else if (en !== 1'b0 || stage_num !== 3'(stage)) begin
                n_fail++;
                $display("FAIL clear_pause: got en=%0b stage=%0d required 0 %0d", en, stage_num, stage);
            end
        end
        if (stage != 4) begin
            if ($urandom_range(0, 1) == 1) kill_cycle();
            else cyc();
            died = 1'b1; cyc(); died = 1'b0;
        end
        n_tests++;
        if (score !== 16'(exp_score) || score8 !== 8'(exp_score8)) begin
            n_fail++;
            $display("FAIL clear_score_s%0d: got %0d/%0d required %0d/%0d",
                     stage, score, score8, exp_score, exp_score8);
        end
    endtask

    task automatic pause_to_load(input int next_stage, input bit hold);
        int pulses = 0;
        while (pulses < 100) begin
            repeat ($urandom_range(0, 3)) cyc();
            sof = 1'b1; cyc(); sof = 1'b0;
            pulses++;
            if (srst === 1'b0) break;
        end
        n_tests++;
        if (pulses != 60 || stage_num !== 3'(next_stage)) begin
            n_fail++;
            $display("FAIL pause_frames: got pulses=%0d stage=%0d required 60 %0d", pulses, stage_num, next_stage);
        end
        alld = hold;
        cyc();
        n_tests++;
        if (srst !== 1'b1 || en !== 1'b1 || stage_num !== 3'(next_stage)) begin
            n_fail++;
            $display("FAIL next_stage_entry: got srst=%0b en=%0b stage=%0d required 1 1 %0d",
                     srst, en, stage_num, next_stage);
        end
    endtask

    task automatic test_win_restart();
        died = 1'b1; cyc(); died = 1'b0;
        n_tests++;
        if (score !== 16'(exp_score) || won !== 1'b1) begin
            n_fail++;
            $display("FAIL win_frozen: got score=%0d won=%0b required %0d 1", score, won, exp_score);
        end
        start = 1'b1; cyc(); start = 1'b0;
        exp_score = 0; exp_score8 = 0;
        n_tests++;
        if (srst !== 1'b0 || won !== 1'b0 || stage_num !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_load: got srst=%0b won=%0b stage=%0d required 0 0 1", srst, won, stage_num);
        end
        cyc();
        n_tests++;
        if (stage_num !== 3'd1 || en !== 1'b1 || score !== 16'd0 || score8 !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_play: got stage=%0d en=%0b score=%0d/%0d required 1 1 0/0",
                     stage_num, en, score, score8);
        end
    endtask

    task automatic test_ignored_start();
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        n_tests++;
        if (srst !== 1'b1 || en !== 1'b1 || stage_num !== 3'd1) begin
            n_fail++;
            $display("FAIL start_in_play: got srst=%0b en=%0b stage=%0d required 1 1 1", srst, en, stage_num);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 30; i++) begin
            kill_cycle();
            n_tests++;
            if (score8 !== 8'(exp_score8)) begin
                n_fail++;
                $display("FAIL sat8_kill%0d: got %0d required %0d", i, score8, exp_score8);
            end
            if ($urandom_range(0, 3) == 0) cyc();
        end
        n_tests++;
        if (score !== 16'(exp_score) || score8 !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: got %0d/%0d required %0d/255", score, score8, exp_score);
        end
    endtask

    task automatic test_death();
        sof = 1'b1; cyc(); sof = 1'b0;
        pdead = 1'b1; alld = 1'b1;
        died = 1'($urandom_range(0, 1));
        cyc();
        if (died) begin
            exp_score  = sat(exp_score + 10, 65535);
            exp_score8 = sat(exp_score8 + 10, 255);
        end
        died = 1'b0; alld = 1'b0;
`ifdef STAGE_SEQ_LIVES_EN
        exp_lives = 2;
        n_tests++;
        if (lives !== 2'(exp_lives) || srst !== 1'b0 || stage_num !== 3'd1 || over !== 1'b0) begin
            n_fail++;
            $display("FAIL death_replay: got lives=%0d srst=%0b stage=%0d over=%0b required 2 0 1 0",
                     lives, srst, stage_num, over);
        end
        repeat (4) cyc();
        n_tests++;
        if (lives !== 2'(exp_lives) || en !== 1'b1 || score !== 16'(exp_score)) begin
            n_fail++;
            $display("FAIL death_held: got lives=%0d en=%0b score=%0d required 2 1 %0d",
                     lives, en, score, exp_score);
        end
`else
        n_tests++;
        if (over !== 1'b1 || en !== 1'b0 || stage_num !== 3'd0 || won !== 1'b0 || lives !== 2'd1) begin
            n_fail++;
            $display("FAIL death_lose: got over=%0b en=%0b stage=%0d won=%0b lives=%0d required 1 0 0 0 1",
                     over, en, stage_num, won, lives);
        end
        died = 1'b1; cyc(); died = 1'b0;
        n_tests++;
        if (score !== 16'(exp_score) || over !== 1'b1) begin
            n_fail++;
            $display("FAIL lose_frozen: got score=%0d over=%0b required %0d 1", score, over, exp_score);
        end
`endif
        pdead = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        play_clear(1, 1'b0);
        pause_to_load(2, 1'b1);
        play_clear(2, 1'b1);
        pause_to_load(4, 1'b0);
        play_clear(4, 1'b0);
        test_win_restart();
        test_ignored_start();
        test_saturation();
        test_death();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
